mmu_ram_seq: RTL and testbench
==============================

Name: mmu_ram_seq

Overview:
- Sequencer for the external 256x8 MMU mapping RAM (MMU_ADDR/MMU_DATA/MMU_nRD/MMU_nWR).
- Shares the RAM between two requesters:
  - translation lookups, which have priority;
  - CPU-initiated mapping-register writes, held in a 1-deep buffer.
- After reset it fills the RAM with an identity map before any lookup is served.
- Sits inside the MMU CPLD between the CPU-side decode and the MMU RAM pins.

Parameters:
- RD_CYCLES, 2, cycles MMU_nRD is held low before read data is captured (min 1).
- WR_CYCLES, 1, cycles MMU_nWR is held low per write (min 1).
- INIT_ENABLE, 1, 1 = identity-fill the RAM after reset; 0 = go straight to IDLE.

Ports:
- CLKX4  in  1  the single clock (4x E).
- nRESET  in  1  synchronous, active-low reset.
- xl_req  in  1  translation request (level); held by requester until xl_valid.
- xl_idx  in  8  RAM index to look up.
- xl_valid  out  1  one-cycle pulse: xl_data updated.
- xl_data  out  8  last captured translation; holds between lookups.
- wr_req  in  1  one-cycle pulse: queue a mapping write.
- wr_idx  in  8  write index.
- wr_data  in  8  write data.
- wr_pend  out  1  write buffer occupied.
- wr_ovf  out  1  sticky: a wr_req was dropped.
- init_done  out  1  identity fill complete.
- MMU_ADDR  out  8  RAM address.
- MMU_nRD  out  1  RAM output enable, active low.
- MMU_nWR  out  1  RAM write strobe, active low.
- MMU_DATA_in  in  8  RAM read data.
- MMU_DATA_out  out  8  RAM write data.
- MMU_DATA_oe  out  1  drive MMU_DATA.

Behaviour:
- Reset, sampled on the CLKX4 edge with nRESET=0:
  - MMU_nRD=1, MMU_nWR=1, MMU_DATA_oe=0, MMU_ADDR=0, MMU_DATA_out=0;
  - xl_valid=0, xl_data=0, wr_pend=0, wr_ovf=0, init_done=0;
  - init counter=0; state=INIT_SETUP (IDLE if INIT_ENABLE=0).
  - Reset mid-operation aborts any cycle and restarts the init from index 0.
- States: INIT_SETUP, INIT_STROBE, INIT_HOLD, IDLE, READ, WSETUP, WSTROBE, WHOLD.
- Write cycle (init and buffered writes alike):
  - SETUP: 1 cycle; address and data driven, oe=1, nWR=1.
  - STROBE: WR_CYCLES cycles with nWR=0.
  - HOLD: 1 cycle; nWR=1, address, data and oe still held.
  - oe drops on leaving HOLD. Total 2+WR_CYCLES cycles.
  - Address and data never change while nWR=0.
- Init:
  - Entry i is written with data i, for i = 0..255.
  - After HOLD of i=255: init_done=1 from the next edge, state goes to IDLE.
  - Default duration is 768 cycles.
  - xl_req is not served during init.
  - wr_req is accepted into the buffer during init and applied after it.
- IDLE, priority order:
  1. xl_req=1 -> READ. MMU_ADDR=xl_idx and nRD=0 from that edge.
  2. else wr_pend=1 -> WSETUP, using the buffered idx/data.
  3. else remain in IDLE, with nRD=nWR=1 and oe=0.
- READ:
  - nRD stays low for RD_CYCLES cycles.
  - At the edge ending the last cycle: xl_data<=MMU_DATA_in, xl_valid=1, nRD=1, state -> IDLE.
  - xl_req is ignored in the cycle where xl_valid=1.
  - Latency from acceptance edge to xl_valid is RD_CYCLES cycles; back-to-back lookups take RD_CYCLES+1 cycles.
- Write buffer:
  - wr_req with wr_pend=0 -> capture idx/data, wr_pend=1.
  - wr_pend clears at the edge leaving WHOLD.
  - wr_req with wr_pend=1 (including the clearing edge) is dropped and sets wr_ovf; the buffered entry is unchanged.
- Contention:
  - xl_req arriving during a write waits until the write completes. A lookup of the same index after the write returns the new data.
  - xl_req and a pending write to the same index in IDLE on the same edge: the read wins and returns the old data.
- MMU_ADDR holds its last value when idle.

Test Plan:
- Reset then free-run, INIT_ENABLE=1, WR_CYCLES=1 -> 256 writes with ADDR=DATA=i, each 3 cycles with nWR low for 1. init_done rises 768 cycles after reset release. nRD stays 1 throughout.
- After init, hold xl_req=1 with xl_idx=0x5A and RAM model returning 0x5A -> nRD low for exactly 2 cycles. xl_valid pulses once with xl_data=0x5A. The second lookup starts 3 cycles after the first.
- wr_req (idx 0x10, data 0xC3) in IDLE -> wr_pend=1. Write sequence with ADDR 0x10, DATA 0xC3, oe over 3 cycles. wr_pend=0 after WHOLD. Next lookup of 0x10 returns 0xC3.
- xl_req (idx 0x10) and wr_req (0x10, 0x77) on the same edge -> read served first returning the old value. Write follows immediately. A second wr_req while pending -> dropped and wr_ovf=1.
- nRESET=0 for one edge at init index 100, mid-STROBE -> nWR=1 and oe=0 on that edge. Init restarts at index 0. init_done=0 until the full 768 cycles complete.
- wr_req during init (idx 0x20, data 0xEE) -> buffered. Applied after the identity fill, so entry 0x20 ends as 0xEE.

Source files
------------

// File: rtl/mmu_ram_seq.sv
// Sequences the external 256x8 MMU RAM: identity fill after reset, prioritised lookups, one buffered write.
// Lookup latency RD_CYCLES from the accepting edge; writes take 2+WR_CYCLES pin cycles plus one dispatch cycle.
// Lookups are held off by the fill and by an in-flight write; a wr_req that meets a full buffer is dropped and flagged in wr_ovf.
module mmu_ram_seq #(
    parameter int RD_CYCLES   = 2,
    parameter int WR_CYCLES   = 1,
    parameter int INIT_ENABLE = 1
) (
    input  logic       CLKX4,
    input  logic       nRESET,
    input  logic       xl_req,
    input  logic [7:0] xl_idx,
    output logic       xl_valid,
    output logic [7:0] xl_data,
    input  logic       wr_req,
    input  logic [7:0] wr_idx,
    input  logic [7:0] wr_data,
    output logic       wr_pend,
    output logic       wr_ovf,
    output logic       init_done,
    output logic [7:0] MMU_ADDR,
    output logic       MMU_nRD,
    output logic       MMU_nWR,
    input  logic [7:0] MMU_DATA_in,
    output logic [7:0] MMU_DATA_out,
    output logic       MMU_DATA_oe
);

    // Each state names the bus phase that is driven onto the pins at the next edge,
    // so every RAM pin is a plain register and the reset cycle stays quiet.
    typedef enum logic [2:0] {
        INIT_SETUP,
        INIT_STROBE,
        INIT_HOLD,
        IDLE,
        READ,
        WSETUP,
        WSTROBE,
        WHOLD
    } state_t;

    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);
    localparam state_t     RST_ST  = (INIT_ENABLE != 0) ? INIT_SETUP : IDLE;

    state_t     state, state_nxt;
    logic [7:0] init_cnt, init_cnt_nxt;
    logic [7:0] tmr, tmr_nxt;
    logic [7:0] buf_idx, buf_idx_nxt;
    logic [7:0] buf_dat, buf_dat_nxt;
    logic [7:0] addr_nxt, dout_nxt, xl_data_nxt;
    logic       oe_nxt, nrd_nxt, nwr_nxt;
    logic       xl_valid_nxt, wr_pend_nxt, wr_ovf_nxt, init_done_nxt;

    // Register the FSM, the write buffer and every pin; synchronous reset aborts any bus cycle.
    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            state        <= RST_ST;
            init_cnt     <= 8'h00;
            tmr          <= 8'h00;
            buf_idx      <= 8'h00;
            buf_dat      <= 8'h00;
            MMU_ADDR     <= 8'h00;
            MMU_DATA_out <= 8'h00;
            MMU_DATA_oe  <= 1'b0;
            MMU_nRD      <= 1'b1;
            MMU_nWR      <= 1'b1;
            xl_valid     <= 1'b0;
            xl_data      <= 8'h00;
            wr_pend      <= 1'b0;
            wr_ovf       <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            init_cnt     <= init_cnt_nxt;
            tmr          <= tmr_nxt;
            buf_idx      <= buf_idx_nxt;
            buf_dat      <= buf_dat_nxt;
            MMU_ADDR     <= addr_nxt;
            MMU_DATA_out <= dout_nxt;
            MMU_DATA_oe  <= oe_nxt;
            MMU_nRD      <= nrd_nxt;
            MMU_nWR      <= nwr_nxt;
            xl_valid     <= xl_valid_nxt;
            xl_data      <= xl_data_nxt;
            wr_pend      <= wr_pend_nxt;
            wr_ovf       <= wr_ovf_nxt;
            init_done    <= init_done_nxt;
        end
    end

    // Next state, next pin values and write-buffer bookkeeping.
    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        tmr_nxt       = tmr;
        buf_idx_nxt   = buf_idx;
        buf_dat_nxt   = buf_dat;
        addr_nxt      = MMU_ADDR;
        dout_nxt      = MMU_DATA_out;
        oe_nxt        = MMU_DATA_oe;
        nrd_nxt       = MMU_nRD;
        nwr_nxt       = MMU_nWR;
        xl_valid_nxt  = 1'b0;
        xl_data_nxt   = xl_data;
        wr_pend_nxt   = wr_pend;
        wr_ovf_nxt    = wr_ovf;
        init_done_nxt = init_done;

        // The buffer accepts regardless of state; the clear in WHOLD below
        // sees the registered wr_pend, so a request on that edge is dropped.
        if (wr_req) begin
            if (wr_pend) begin
                wr_ovf_nxt = 1'b1;
            end else begin
                wr_pend_nxt = 1'b1;
                buf_idx_nxt = wr_idx;
                buf_dat_nxt = wr_data;
            end
        end

        case (state)
            INIT_SETUP: begin
                addr_nxt  = init_cnt;
                dout_nxt  = init_cnt;
                oe_nxt    = 1'b1;
                nwr_nxt   = 1'b1;
                nrd_nxt   = 1'b1;
                tmr_nxt   = 8'h00;
                state_nxt = INIT_STROBE;
            end
            INIT_STROBE: begin
                nwr_nxt = 1'b0;
                if (tmr == WR_LAST) begin
                    tmr_nxt   = 8'h00;
                    state_nxt = INIT_HOLD;
                end else begin
                    tmr_nxt = tmr + 8'd1;
                end
            end
            INIT_HOLD: begin
                nwr_nxt = 1'b1;
                if (init_cnt == 8'hFF) begin
                    state_nxt = IDLE;
                end else begin
                    init_cnt_nxt = init_cnt + 8'd1;
                    state_nxt    = INIT_SETUP;
                end
            end
            IDLE: begin
                oe_nxt  = 1'b0;
                nwr_nxt = 1'b1;
                nrd_nxt = 1'b1;
                tmr_nxt = 8'h00;
                // The first IDLE edge only publishes init_done; service starts on the next one.
                if (!init_done) begin
                    init_done_nxt = 1'b1;
                end else if (xl_req) begin
                    addr_nxt  = xl_idx;
                    nrd_nxt   = 1'b0;
                    state_nxt = READ;
                end else if (wr_pend) begin
                    state_nxt = WSETUP;
                end
            end
            READ: begin
                if (tmr == RD_LAST) begin
                    xl_data_nxt  = MMU_DATA_in;
                    xl_valid_nxt = 1'b1;
                    nrd_nxt      = 1'b1;
                    tmr_nxt      = 8'h00;
                    state_nxt    = IDLE;
                end else begin
                    tmr_nxt = tmr + 8'd1;
                end
            end
            WSETUP: begin
                addr_nxt  = buf_idx;
                dout_nxt  = buf_dat;
                oe_nxt    = 1'b1;
                nwr_nxt   = 1'b1;
                nrd_nxt   = 1'b1;
                tmr_nxt   = 8'h00;
                state_nxt = WSTROBE;
            end
            WSTROBE: begin
                nwr_nxt = 1'b0;
                if (tmr == WR_LAST) begin
                    tmr_nxt   = 8'h00;
                    state_nxt = WHOLD;
                end else begin
                    tmr_nxt = tmr + 8'd1;
                end
            end
            WHOLD: begin
                nwr_nxt     = 1'b1;
                wr_pend_nxt = 1'b0;
                state_nxt   = IDLE;
            end
            default: state_nxt = RST_ST;
        endcase
    end

endmodule

// File: tb/tb_mmu_ram_seq.sv
// Directed bench for mmu_ram_seq with a behavioural RAM on the pins and a lookup scoreboard.
// Samples on the falling edge; expected lookup data comes from a bench-side map of the writes issued.
// Each lookup pushes its expected data when the request is driven and pops it at xl_valid.
module tb_mmu_ram_seq;

    localparam int RD = 2;
    localparam int WR = 1;

    logic       CLKX4 = 1'b0;
    logic       nRESET;
    logic       xl_req;
    logic [7:0] xl_idx;
    logic       xl_valid;
    logic [7:0] xl_data;
    logic       wr_req;
    logic [7:0] wr_idx;
    logic [7:0] wr_data;
    logic       wr_pend;
    logic       wr_ovf;
    logic       init_done;
    logic [7:0] MMU_ADDR;
    logic       MMU_nRD;
    logic       MMU_nWR;
    logic [7:0] MMU_DATA_in;
    logic [7:0] MMU_DATA_out;
    logic       MMU_DATA_oe;

    logic [7:0] ram     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] sb_q [$];
    logic       scramble;
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 CLKX4 = ~CLKX4;
    always @(posedge CLKX4) cyc <= cyc + 1;

    mmu_ram_seq #(.RD_CYCLES(RD), .WR_CYCLES(WR), .INIT_ENABLE(1)) dut (
        .CLKX4(CLKX4), .nRESET(nRESET),
        .xl_req(xl_req), .xl_idx(xl_idx), .xl_valid(xl_valid), .xl_data(xl_data),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_pend(wr_pend), .wr_ovf(wr_ovf), .init_done(init_done),
        .MMU_ADDR(MMU_ADDR), .MMU_nRD(MMU_nRD), .MMU_nWR(MMU_nWR),
        .MMU_DATA_in(MMU_DATA_in), .MMU_DATA_out(MMU_DATA_out), .MMU_DATA_oe(MMU_DATA_oe)
    );

    // Behavioural RAM: scrambled on request so an identity fill must really happen.
    always @(posedge CLKX4) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i ^ 8'hA5);
        end else if (!MMU_nWR && MMU_DATA_oe) begin
            ram[MMU_ADDR] <= MMU_DATA_out;
        end
    end
    assign MMU_DATA_in = MMU_nRD ? 8'h00 : ram[MMU_ADDR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i);
    endtask

    // Walks the fill cycle by cycle: ADDR=DATA=k/3, oe on, nWR low only in the middle cycle.
    task automatic check_init(input int upto);
        logic [19:0] exp_v;
        for (int k = 0; k < upto; k++) begin
            @(negedge CLKX4);
            wr_req = 1'b0;
            exp_v = {8'(k / 3), 8'(k / 3), 1'b1, (k % 3 == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0};
            chk("init_cycle", 32'({MMU_ADDR, MMU_DATA_out, MMU_DATA_oe, MMU_nWR, MMU_nRD, init_done}),
                32'(exp_v));
        end
    endtask

    task automatic start_lookup(input logic [7:0] idx);
        xl_idx = idx;
        xl_req = 1'b1;
        sb_q.push_back(exp_mem[idx]);
    endtask

    task automatic finish_lookup(input bit keep, output int start_cyc, output int low_cnt);
        bit got;
        logic [7:0] e;
        got       = 1'b0;
        start_cyc = -1;
        low_cnt   = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge CLKX4);
            if (!MMU_nRD) begin
                if (start_cyc < 0) start_cyc = cyc;
                low_cnt++;
            end
            if (xl_valid) got = 1'b1;
        end
        chk("xl_valid_seen", 32'(got), 1);
        if (got && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("xl_data", 32'(xl_data), 32'(e));
        end
        if (!keep) xl_req = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] idx);
        int s, l;
        start_lookup(idx);
        finish_lookup(1'b0, s, l);
        chk("rd_low_cycles", l, RD);
    endtask

    // Follows one write on the pins from oe rising to oe falling.
    task automatic watch_write(input logic [7:0] idx, input logic [7:0] dat);
        int  oe_n, wr_n;
        bit  seen, done;
        oe_n = 0; wr_n = 0; seen = 1'b0; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge CLKX4);
            if (MMU_DATA_oe) begin
                seen = 1'b1;
                oe_n++;
                chk("wr_addr_data", 32'({MMU_ADDR, MMU_DATA_out, MMU_nRD}), 32'({idx, dat, 1'b1}));
                if (!MMU_nWR) wr_n++;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        chk("wr_oe_cycles", oe_n, 2 + WR);
        chk("wr_strobe_cycles", wr_n, WR);
        exp_mem[idx] = dat;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int s1, l1, s2, l2;
        nRESET = 1'b0; scramble = 1'b1;
        xl_req = 1'b0; xl_idx = 8'h00;
        wr_req = 1'b0; wr_idx = 8'h00; wr_data = 8'h00;
        set_identity();
        repeat (3) @(posedge CLKX4);
        @(negedge CLKX4);
        scramble = 1'b0;

        // Reset state
        chk("rst_strobes", 32'({MMU_nRD, MMU_nWR, MMU_DATA_oe}), 32'(3'b110));
        chk("rst_addr_data", 32'({MMU_ADDR, MMU_DATA_out}), 0);
        chk("rst_flags", 32'({xl_valid, wr_pend, wr_ovf, init_done}), 0);
        chk("rst_xl_data", 32'(xl_data), 0);

        // Identity fill, 768 cycles
        nRESET = 1'b1;
        check_init(768);
        @(negedge CLKX4);
        chk("init_done_rise", 32'({init_done, MMU_DATA_oe, MMU_nWR, MMU_nRD}), 32'(4'b1011));

        // Back-to-back lookups of 0x5A with xl_req held
        start_lookup(8'h5A);
        finish_lookup(1'b1, s1, l1);
        chk("rd_low_cycles_1", l1, RD);
        start_lookup(8'h5A);
        finish_lookup(1'b0, s2, l2);
        chk("rd_low_cycles_2", l2, RD);
        chk("b2b_spacing", s2 - s1, RD + 1);
        @(negedge CLKX4);
        chk("xl_valid_pulse", 32'(xl_valid), 0);
        chk("xl_data_hold", 32'(xl_data), 32'h5A);

        // Fill boundaries
        lookup(8'h00);
        lookup(8'hFF);

        // Buffered write in IDLE, then read back
        @(negedge CLKX4);
        wr_idx = 8'h10; wr_data = 8'hC3; wr_req = 1'b1;
        @(negedge CLKX4);
        wr_req = 1'b0;
        chk("wr_pend_set", 32'(wr_pend), 1);
        watch_write(8'h10, 8'hC3);
        chk("wr_pend_clear", 32'(wr_pend), 0);
        chk("wr_ovf_clean", 32'(wr_ovf), 0);
        lookup(8'h10);

        // Read and write to the same index on the same edge; second write dropped
        @(negedge CLKX4);
        start_lookup(8'h10);
        wr_idx = 8'h10; wr_data = 8'h77; wr_req = 1'b1;
        @(negedge CLKX4);
        chk("wr_pend_during_rd", 32'(wr_pend), 1);
        wr_data = 8'h55;
        @(negedge CLKX4);
        wr_req = 1'b0;
        chk("wr_ovf_set", 32'(wr_ovf), 1);
        finish_lookup(1'b0, s1, l1);
        watch_write(8'h10, 8'h77);
        lookup(8'h10);

        // Re-init, then reset for one edge in the strobe of entry 100
        @(negedge CLKX4);
        nRESET = 1'b0; scramble = 1'b1;
        @(negedge CLKX4);
        scramble = 1'b0; nRESET = 1'b1;
        set_identity();
        check_init(302);
        nRESET = 1'b0;
        @(negedge CLKX4);
        chk("midrst_strobes", 32'({MMU_nWR, MMU_DATA_oe, MMU_nRD}), 32'(3'b101));
        chk("midrst_addr", 32'(MMU_ADDR), 0);
        chk("midrst_flags", 32'({init_done, wr_ovf, wr_pend, xl_valid}), 0);
        chk("midrst_xl_data", 32'(xl_data), 0);

        // Restart from index 0 with a write queued during the fill
        nRESET = 1'b1;
        wr_idx = 8'h20; wr_data = 8'hEE; wr_req = 1'b1;
        check_init(768);
        @(negedge CLKX4);
        chk("reinit_done", 32'({init_done, wr_pend}), 32'(2'b11));
        watch_write(8'h20, 8'hEE);
        lookup(8'h20);
        lookup(8'h21);
        lookup(8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
